// File: rtl/ro_cache_ctrl_regfile.sv
`default_nettype none
// ============================================================================
// Module      : ro_cache_ctrl_regfile
// Description : Memory-mapped control registers for the read-only caches.
//               Holds the cache enable and per-rule start/end addresses, and
//               runs a multi-cache flush handshake with per-cache completion.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_cache_ctrl_regfile #(
    parameter int NUM_ADDR_RULES = 4,
    parameter int NUM_CACHES     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic                                 req_write_i,
    input  logic [ADDR_WIDTH-1:0]                req_addr_i,
    input  logic [DATA_WIDTH-1:0]                req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]              req_strb_i,
    output logic                                 resp_valid_o,
    output logic [DATA_WIDTH-1:0]                resp_rdata_o,
    output logic                                 resp_error_o,
    output logic                                 enable_o,
    output logic [NUM_ADDR_RULES*ADDR_WIDTH-1:0] start_addr_o,
    output logic [NUM_ADDR_RULES*ADDR_WIDTH-1:0] end_addr_o,
    output logic [NUM_ADDR_RULES-1:0]            rule_valid_o,
    output logic [NUM_CACHES-1:0]                flush_valid_o,
    input  logic [NUM_CACHES-1:0]                flush_ready_i,
    output logic                                 flush_busy_o
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    // The FLUSH read word has bit0 for busy, so at most DATA_WIDTH-1 done bits fit.
    localparam int c_DONE_VIS = (NUM_CACHES > DATA_WIDTH - 1) ? DATA_WIDTH - 1 : NUM_CACHES;

    localparam logic [5:0] c_WORD_ENABLE = 6'd0;
    localparam logic [5:0] c_WORD_FLUSH  = 6'd1;
    localparam logic [5:0] c_WORD_INFO   = 6'd2;

    localparam logic [DATA_WIDTH-1:0] c_INFO =
        DATA_WIDTH'({16'(NUM_CACHES), 16'(NUM_ADDR_RULES)});

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_enable;
    logic [ADDR_WIDTH-1:0]   r_start [NUM_ADDR_RULES];
    logic [ADDR_WIDTH-1:0]   r_end   [NUM_ADDR_RULES];

    logic [NUM_CACHES-1:0]   r_flush_valid;
    logic [NUM_CACHES-1:0]   w_flush_valid_nxt;
    logic [NUM_CACHES-1:0]   r_done;
    logic [NUM_CACHES-1:0]   w_done_nxt;
    logic [NUM_CACHES-1:0]   w_ack;

    logic                    r_resp_valid;
    logic                    r_resp_error;
    logic [DATA_WIDTH-1:0]   r_resp_rdata;

    logic [5:0]              w_word;
    logic [NUM_ADDR_RULES-1:0] w_start_hit;
    logic [NUM_ADDR_RULES-1:0] w_end_hit;
    logic                    w_hit_enable;
    logic                    w_hit_flush;
    logic                    w_hit_info;
    logic                    w_hit_rule;
    logic                    w_err;
    logic                    w_stall;
    logic                    w_accept;
    logic                    w_wr_ok;
    logic                    w_flush_start;
    logic [DATA_WIDTH-1:0]   w_flush_rd;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_unused;

    // Merge write data into an existing value, byte lane by byte lane.
    function automatic logic [DATA_WIDTH-1:0] f_apply_strb(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [c_STRB_W-1:0]   strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < c_STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Address decode: only the word index in bits [7:2] matters.
    // ------------------------------------------------------------------
    assign w_word   = req_addr_i[7:2];
    assign w_unused = ^{req_addr_i[ADDR_WIDTH-1:8], req_addr_i[1:0]};

    generate
        for (genvar i = 0; i < NUM_ADDR_RULES; i++) begin : g_rule_dec
            assign w_start_hit[i] = (w_word == 6'(4 + 2*i));
            assign w_end_hit[i]   = (w_word == 6'(5 + 2*i));
        end
    endgenerate

    assign w_hit_enable = (w_word == c_WORD_ENABLE);
    assign w_hit_flush  = (w_word == c_WORD_FLUSH);
    assign w_hit_info   = (w_word == c_WORD_INFO);
    assign w_hit_rule   = (|w_start_hit) || (|w_end_hit);

    // Unmapped offsets and writes to the read-only INFO word are errors.
    assign w_err = !(w_hit_enable || w_hit_flush || w_hit_info || w_hit_rule)
                   || (req_write_i && w_hit_info);

    // Rules and enable are frozen while a flush is running.
    assign w_stall     = (r_state == ST_FLUSH) && req_write_i && (w_hit_enable || w_hit_rule);
    assign req_ready_o = !w_stall;
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_wr_ok     = w_accept && req_write_i && !w_err;

    // A FLUSH write while busy is silently ignored.
    assign w_flush_start = w_wr_ok && w_hit_flush && req_strb_i[0] && req_wdata_i[0]
                           && (r_state == ST_IDLE);

    // Enable bit register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_enable <= 1'b0;
        end else if (w_wr_ok && w_hit_enable && req_strb_i[0]) begin
            r_enable <= req_wdata_i[0];
        end
    end

    // Per-rule start/end address registers with byte-strobe writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ADDR_RULES; i++) begin
                r_start[i] <= '0;
                r_end[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ADDR_RULES; i++) begin
                if (w_wr_ok && w_start_hit[i]) begin
                    r_start[i] <= f_apply_strb(r_start[i], req_wdata_i, req_strb_i);
                end
                if (w_wr_ok && w_end_hit[i]) begin
                    r_end[i] <= f_apply_strb(r_end[i], req_wdata_i, req_strb_i);
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_ADDR_RULES; i++) begin : g_rule_out
            assign start_addr_o[i*ADDR_WIDTH +: ADDR_WIDTH] = r_start[i];
            assign end_addr_o[i*ADDR_WIDTH +: ADDR_WIDTH]   = r_end[i];
            assign rule_valid_o[i] = (r_end[i] > r_start[i]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Flush handshake FSM
    // ------------------------------------------------------------------
    assign w_ack = r_flush_valid & flush_ready_i;

    // Flush state, outstanding requests and per-cache completion mask.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_flush_valid <= '0;
            r_done        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_flush_valid <= w_flush_valid_nxt;
            r_done        <= w_done_nxt;
        end
    end

    // Next-state: launch all caches at once, retire each on its own acknowledge.
    always_comb begin
        w_state_nxt       = r_state;
        w_flush_valid_nxt = r_flush_valid;
        w_done_nxt        = r_done;
        case (r_state)
            ST_IDLE: begin
                if (w_flush_start) begin
                    w_state_nxt       = ST_FLUSH;
                    w_flush_valid_nxt = '1;
                    w_done_nxt        = '0;
                end
            end
            ST_FLUSH: begin
                w_flush_valid_nxt = r_flush_valid & ~w_ack;
                w_done_nxt        = r_done | w_ack;
                if (&(r_done | w_ack)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign flush_valid_o = r_flush_valid;
    assign flush_busy_o  = (r_state == ST_FLUSH);
    assign enable_o      = r_enable;

    // ------------------------------------------------------------------
    // Read path and response
    // ------------------------------------------------------------------
    // FLUSH status word: busy in bit0, done mask above it.
    always_comb begin
        w_flush_rd    = '0;
        w_flush_rd[0] = flush_busy_o;
        for (int c = 0; c < c_DONE_VIS; c++) begin
            w_flush_rd[c+1] = r_done[c];
        end
    end

    // Read data multiplexer over all mapped words.
    always_comb begin
        w_rdata = '0;
        if (w_hit_enable) begin
            w_rdata[0] = r_enable;
        end
        if (w_hit_flush) begin
            w_rdata = w_flush_rd;
        end
        if (w_hit_info) begin
            w_rdata = c_INFO;
        end
        for (int i = 0; i < NUM_ADDR_RULES; i++) begin
            if (w_start_hit[i]) begin
                w_rdata = r_start[i];
            end
            if (w_end_hit[i]) begin
                w_rdata = r_end[i];
            end
        end
    end

    // One-cycle response pulse; data only for successful reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= w_accept;
            r_resp_error <= w_accept && w_err;
            r_resp_rdata <= (w_accept && !req_write_i && !w_err) ? w_rdata : '0;
        end
    end

    assign resp_valid_o = r_resp_valid;
    assign resp_error_o = r_resp_error;
    assign resp_rdata_o = r_resp_rdata;

endmodule
`default_nettype wire
